id_ex_latch: RTL

- Pipeline register between the decode stage and the execute stage.
- Captures decoded operands, register addresses and control bits, and presents them to execute: ALU, ALU control (opcode/funct), shamt mux, forwarding unit.
- Supports debug-unit freeze, downstream hold, hazard-unit bubble insertion and branch flush.
- Keeps a saturating bubble counter for the debug unit.

---
 rtl/id_ex_latch_pkg.sv | 21 ++
 rtl/id_ex_latch_sat_counter.sv | 31 +++
 rtl/id_ex_latch.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/id_ex_latch_pkg.sv
// Execute-stage constants shared by decode and execute: NOP encoding and
// control-bit layout of the 8-bit ctrl bundle.
package id_ex_latch_pkg;

   localparam int unsigned NB_CTRL = 8;

   // ctrl bundle is {reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch, jump}
   localparam int unsigned CTRL_REG_DST    = 7;
   localparam int unsigned CTRL_ALU_SRC    = 6;
   localparam int unsigned CTRL_MEM_READ   = 5;
   localparam int unsigned CTRL_MEM_WRITE  = 4;
   localparam int unsigned CTRL_MEM_TO_REG = 3;
   localparam int unsigned CTRL_REG_WRITE  = 2;
   localparam int unsigned CTRL_BRANCH     = 1;
   localparam int unsigned CTRL_JUMP       = 0;

   // opcode 0 / funct 0 decodes as SLL r0,r0,0
   localparam logic [5:0] NOP_OPCODE = 6'h00;
   localparam logic [5:0] NOP_FUNCT  = 6'h00;

endpackage

// File: rtl/id_ex_latch_sat_counter.sv
// Saturating up-counter with synchronous active-low reset; sticks at all ones.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (i_inc && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_count = count_q;

endmodule

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with debug freeze, downstream hold, bubble insertion,
// branch flush (remembered across a hold) and a saturating bubble counter.
module id_ex_latch
   import id_ex_latch_pkg::*;
#(
   parameter int unsigned NB_DATA   = 32,
   parameter int unsigned NB_PC     = 32,
   parameter int unsigned NB_ADDR   = 5,
   parameter int unsigned NB_OPCODE = 6,
   parameter int unsigned NB_FCODE  = 6,
   parameter int unsigned NB_SHAMT  = 5,
   parameter int unsigned NB_CNT    = 16
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_enable,
   input  logic                 i_hold,
   input  logic                 i_flush,
   input  logic                 i_bubble,
   input  logic [NB_PC-1:0]     i_pc4,
   input  logic [NB_DATA-1:0]   i_rs_data,
   input  logic [NB_DATA-1:0]   i_rt_data,
   input  logic [NB_DATA-1:0]   i_imm,
   input  logic [NB_SHAMT-1:0]  i_shamt,
   input  logic [NB_OPCODE-1:0] i_opcode,
   input  logic [NB_FCODE-1:0]  i_funct,
   input  logic [NB_ADDR-1:0]   i_rs,
   input  logic [NB_ADDR-1:0]   i_rt,
   input  logic [NB_ADDR-1:0]   i_rd,
   input  logic [NB_CTRL-1:0]   i_ctrl,
   output logic [NB_PC-1:0]     o_pc4,
   output logic [NB_DATA-1:0]   o_rs_data,
   output logic [NB_DATA-1:0]   o_rt_data,
   output logic [NB_DATA-1:0]   o_imm,
   output logic [NB_SHAMT-1:0]  o_shamt,
   output logic [NB_OPCODE-1:0] o_opcode,
   output logic [NB_FCODE-1:0]  o_funct,
   output logic [NB_ADDR-1:0]   o_rs,
   output logic [NB_ADDR-1:0]   o_rt,
   output logic [NB_ADDR-1:0]   o_rd,
   output logic [NB_CTRL-1:0]   o_ctrl,
   output logic                 o_valid,
   output logic [NB_CNT-1:0]    o_bubble_count
);

   logic [NB_PC-1:0]     pc4_q,     pc4_d;
   logic [NB_DATA-1:0]   rs_data_q, rs_data_d;
   logic [NB_DATA-1:0]   rt_data_q, rt_data_d;
   logic [NB_DATA-1:0]   imm_q,     imm_d;
   logic [NB_SHAMT-1:0]  shamt_q,   shamt_d;
   logic [NB_OPCODE-1:0] opcode_q,  opcode_d;
   logic [NB_FCODE-1:0]  funct_q,   funct_d;
   logic [NB_ADDR-1:0]   rs_q,      rs_d;
   logic [NB_ADDR-1:0]   rt_q,      rt_d;
   logic [NB_ADDR-1:0]   rd_q,      rd_d;
   logic [NB_CTRL-1:0]   ctrl_q,    ctrl_d;
   logic                 valid_q,   valid_d;
   logic                 pend_q,    pend_d;
   logic                 ld_bubble;
   logic                 ld_instr;

   // Freeze beats hold beats flush beats bubble; a flush seen under hold is
   // parked in pend_q (one bit, so repeated flushes collapse to one bubble).
   always_comb begin
      ld_bubble = 1'b0;
      ld_instr  = 1'b0;
      pend_d    = pend_q;
      if (i_enable) begin
         if (i_hold) begin
            if (i_flush) begin
               pend_d = 1'b1;
            end
         end else if (i_flush || pend_q) begin
            ld_bubble = 1'b1;
            pend_d    = 1'b0;
         end else if (i_bubble) begin
            ld_bubble = 1'b1;
         end else begin
            ld_instr = 1'b1;
         end
      end
   end

   always_comb begin
      pc4_d     = pc4_q;
      rs_data_d = rs_data_q;
      rt_data_d = rt_data_q;
      imm_d     = imm_q;
      shamt_d   = shamt_q;
      opcode_d  = opcode_q;
      funct_d   = funct_q;
      rs_d      = rs_q;
      rt_d      = rt_q;
      rd_d      = rd_q;
      ctrl_d    = ctrl_q;
      valid_d   = valid_q;
      if (ld_bubble) begin
         pc4_d     = '0;
         rs_data_d = '0;
         rt_data_d = '0;
         imm_d     = '0;
         shamt_d   = '0;
         opcode_d  = NB_OPCODE'(NOP_OPCODE);
         funct_d   = NB_FCODE'(NOP_FUNCT);
         rs_d      = '0;
         rt_d      = '0;
         rd_d      = '0;
         ctrl_d    = '0;
         valid_d   = 1'b0;
      end else if (ld_instr) begin
         pc4_d     = i_pc4;
         rs_data_d = i_rs_data;
         rt_data_d = i_rt_data;
         imm_d     = i_imm;
         shamt_d   = i_shamt;
         opcode_d  = i_opcode;
         funct_d   = i_funct;
         rs_d      = i_rs;
         rt_d      = i_rt;
         rd_d      = i_rd;
         ctrl_d    = i_ctrl;
         valid_d   = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         pc4_q     <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         shamt_q   <= '0;
         opcode_q  <= '0;
         funct_q   <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         rd_q      <= '0;
         ctrl_q    <= '0;
         valid_q   <= 1'b0;
         pend_q    <= 1'b0;
      end else begin
         pc4_q     <= pc4_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm_q     <= imm_d;
         shamt_q   <= shamt_d;
         opcode_q  <= opcode_d;
         funct_q   <= funct_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         rd_q      <= rd_d;
         ctrl_q    <= ctrl_d;
         valid_q   <= valid_d;
         pend_q    <= pend_d;
      end
   end

   sat_counter #(
      .WIDTH (NB_CNT)
   ) u_bubble_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_inc   (ld_bubble),
      .o_count (o_bubble_count)
   );

   assign o_pc4     = pc4_q;
   assign o_rs_data = rs_data_q;
   assign o_rt_data = rt_data_q;
   assign o_imm     = imm_q;
   assign o_shamt   = shamt_q;
   assign o_opcode  = opcode_q;
   assign o_funct   = funct_q;
   assign o_rs      = rs_q;
   assign o_rt      = rt_q;
   assign o_rd      = rd_q;
   assign o_ctrl    = ctrl_q;
   assign o_valid   = valid_q;

endmodule
